// File: rtl/dma_read_engine.sv
// DMA read engine: streams a block of words from external memory into the
// inactive ping-pong input buffer, with a bounded number of outstanding reads.
module dma_read_engine #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 16,
  parameter int BUF_AW  = 12,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic              dst_buf,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              buf_we_a,
  output logic              buf_we_b,
  output logic [BUF_AW-1:0] buf_waddr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              busy,
  output logic              dma_done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  received;
  logic              sel;
  logic [LEN_W-1:0]  outstanding;
  logic              start_ok;
  logic              take_rsp;
  logic              last_rsp;
  logic              req_fire;

  // The done cycle still counts as busy, so a new start is only taken one cycle later.
  assign busy        = (state != IDLE) || dma_done;
  assign start_ok    = (state == IDLE) && !dma_done && dma_start;
  assign outstanding = issued - received;
  assign take_rsp    = (state == RUN) && mem_rvalid;
  assign last_rsp    = take_rsp && (received == len - 1'b1);
  assign req_fire    = mem_req && mem_ready;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        if (start_ok) state_next = (xfer_len == '0) ? FINISH : RUN;
      end
      RUN: begin
        mem_req = (issued < len) && (outstanding < LEN_W'(MAX_OUT));
        if (mem_req) mem_addr = base + ADDR_W'(issued);
        if (last_rsp) state_next = FINISH;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base      <= '0;
      len       <= '0;
      sel       <= 1'b0;
      issued    <= '0;
      received  <= '0;
      buf_we_a  <= 1'b0;
      buf_we_b  <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
      dma_done  <= 1'b0;
    end else begin
      if (start_ok) begin
        base     <= src_addr;
        len      <= xfer_len;
        sel      <= dst_buf;
        issued   <= '0;
        received <= '0;
      end else begin
        if (req_fire) issued   <= issued + 1'b1;
        if (take_rsp) received <= received + 1'b1;
      end
      buf_we_a <= take_rsp && !sel;
      buf_we_b <= take_rsp && sel;
      if (take_rsp) begin
        buf_waddr <= BUF_AW'(received);
        buf_wdata <= mem_rdata;
      end
      dma_done <= (state == FINISH);
    end
  end

endmodule

// File: tb/tb_dma_read_engine.sv
// Directed bench for dma_read_engine with an in-order, fixed-latency memory
// model and a monitor that checks every request and buffer write.
module tb_dma_read_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dma_start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [15:0] xfer_len = '0;
  logic        dst_buf = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        buf_we_a, buf_we_b;
  logic [11:0] buf_waddr;
  logic [15:0] buf_wdata;
  logic        busy, dma_done;

  dma_read_engine dut (
    .clk(clk), .reset(reset), .dma_start(dma_start), .src_addr(src_addr),
    .xfer_len(xfer_len), .dst_buf(dst_buf), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .buf_we_a(buf_we_a), .buf_we_b(buf_we_b), .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata), .busy(busy), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 2;
  bit rand_ready = 1'b0;
  logic [15:0] lfsr = 16'hACE1;
  logic [31:0] exp_base = '0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] req_log[16];
  logic [31:0] prev_addr = '0;
  bit  prev_stall = 1'b0;
  int  n_iss, n_resp, n_wa, n_wb, wcount, wr_err, addr_err, stall_err;
  int  done_cnt, done_cyc, req_cycles, max_out, last_rv, start_cyc;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  task automatic clear_stats();
    n_iss = 0; n_resp = 0; n_wa = 0; n_wb = 0; wcount = 0; wr_err = 0;
    addr_err = 0; stall_err = 0; done_cnt = 0; done_cyc = 0; req_cycles = 0;
    max_out = 0; last_rv = 0;
    for (int i = 0; i < 16; i++) req_log[i] = '0;
  endtask

  // Memory responder and monitor: inputs change on the falling edge, outputs are sampled 1ns later.
  always @(negedge clk) begin
    cyc++;
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    mem_ready = rand_ready ? lfsr[0] : 1'b1;
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
      n_resp++;
      last_rv = cyc;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    #1;
    if (buf_we_a || buf_we_b) begin
      if (buf_we_a && buf_we_b) wr_err++;
      if (buf_we_a) n_wa++;
      if (buf_we_b) n_wb++;
      if (buf_waddr !== 12'(wcount) || buf_wdata !== mem_word(exp_base + 32'(wcount))) wr_err++;
      wcount++;
    end
    if (dma_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mem_req) req_cycles++;
    if (prev_stall && (mem_req !== 1'b1 || mem_addr !== prev_addr)) stall_err++;
    prev_stall = mem_req && !mem_ready;
    prev_addr  = mem_addr;
    if (mem_req && mem_ready) begin
      if (mem_addr !== exp_base + 32'(n_iss)) addr_err++;
      if (n_iss < 16) req_log[n_iss] = mem_addr;
      q_addr.push_back(mem_addr);
      q_due.push_back(cyc + lat);
      n_iss++;
      if (n_iss - n_resp > max_out) max_out = n_iss - n_resp;
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [15:0] l, input logic d);
    clear_stats();
    exp_base  = a;
    src_addr  = a;
    xfer_len  = l;
    dst_buf   = d;
    dma_start = 1'b1;
    start_cyc = cyc;
    tick(1);
    dma_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick(1);
      k++;
    end
    check_output(tag, 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_ctl"}, {59'd0, mem_req, buf_we_a, buf_we_b, busy, dma_done}, 64'd0);
    check_output({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check_output({tag, "_waddr"}, 64'(buf_waddr), 64'd0);
    check_output({tag, "_wdata"}, 64'(buf_wdata), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_stats();
    tick(3);
    check_idle_outputs("reset");
    reset = 1'b1;
    tick(2);

    // Basic transfer into buffer B with continuous ready, latency 2.
    lat = 2;
    apply_stimulus(32'h100, 16'd8, 1'b1);
    check_output("basic_busy", 64'(busy), 64'd1);
    wait_done("basic_done", 60);
    check_output("basic_busy_in_done", 64'(busy), 64'd1);
    check_output("basic_done_latency", 64'(done_cyc - start_cyc), 64'd12);
    check_output("basic_done_after_rv", 64'(done_cyc - last_rv), 64'd2);
    check_output("basic_issued", 64'(n_iss), 64'd8);
    check_output("basic_addr_err", 64'(addr_err), 64'd0);
    check_output("basic_writes_b", 64'(n_wb), 64'd8);
    check_output("basic_writes_a", 64'(n_wa), 64'd0);
    check_output("basic_wr_err", 64'(wr_err), 64'd0);
    tick(1);
    check_output("basic_idle", {62'd0, busy, dma_done}, 64'd0);
    check_output("basic_done_cnt", 64'(done_cnt), 64'd1);

    // Backpressure with long latency into buffer A.
    lat = 10;
    rand_ready = 1'b1;
    apply_stimulus(32'h2000, 16'd20, 1'b0);
    wait_done("bp_done", 600);
    rand_ready = 1'b0;
    check_output("bp_issued", 64'(n_iss), 64'd20);
    check_output("bp_addr_err", 64'(addr_err), 64'd0);
    check_output("bp_stall_err", 64'(stall_err), 64'd0);
    check_output("bp_max_out_le4", 64'(max_out <= 4), 64'd1);
    check_output("bp_writes_a", 64'(n_wa), 64'd20);
    check_output("bp_writes_b", 64'(n_wb), 64'd0);
    check_output("bp_wr_err", 64'(wr_err), 64'd0);
    tick(2);

    // Zero length, then a back-to-back zero-length start in the first free cycle.
    lat = 2;
    apply_stimulus(32'h3000, 16'd0, 1'b0);
    wait_done("zero_done", 10);
    check_output("zero_latency", 64'(done_cyc - start_cyc), 64'd2);
    check_output("zero_no_req", 64'(req_cycles), 64'd0);
    tick(1);
    apply_stimulus(32'h3100, 16'd0, 1'b1);
    wait_done("b2b_done", 10);
    check_output("b2b_latency", 64'(done_cyc - start_cyc), 64'd2);
    check_output("b2b_no_write", 64'(n_wa + n_wb), 64'd0);
    tick(2);

    // Second start mid-transfer must be ignored.
    lat = 3;
    apply_stimulus(32'h300, 16'd8, 1'b1);
    tick(2);
    src_addr = 32'h999; xfer_len = 16'd2; dst_buf = 1'b0; dma_start = 1'b1;
    tick(1);
    dma_start = 1'b0;
    wait_done("ign_done", 60);
    tick(10);
    check_output("ign_done_cnt", 64'(done_cnt), 64'd1);
    check_output("ign_issued", 64'(n_iss), 64'd8);
    check_output("ign_addr_err", 64'(addr_err), 64'd0);
    check_output("ign_writes", {32'(n_wa), 32'(n_wb)}, {32'd0, 32'd8});
    check_output("ign_wr_err", 64'(wr_err), 64'd0);

    // Source address wraps through zero.
    lat = 1;
    apply_stimulus(32'hFFFF_FFFE, 16'd4, 1'b0);
    wait_done("wrap_done", 40);
    check_output("wrap_a0", 64'(req_log[0]), 64'hFFFF_FFFE);
    check_output("wrap_a1", 64'(req_log[1]), 64'hFFFF_FFFF);
    check_output("wrap_a2", 64'(req_log[2]), 64'h0);
    check_output("wrap_a3", 64'(req_log[3]), 64'h1);
    check_output("wrap_wr_err", 64'(wr_err), 64'd0);
    tick(2);

    // Reset after three words are written; late responses must be dropped.
    lat = 4;
    apply_stimulus(32'h400, 16'd8, 1'b0);
    for (int k = 0; k < 100 && wcount < 3; k++) tick(1);
    check_output("rst_reached3", 64'(wcount >= 3), 64'd1);
    reset = 1'b0;
    clear_stats();
    tick(1);
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    for (int k = 0; k < 50 && q_addr.size() > 0; k++) tick(1);
    tick(2);
    check_output("rst_drained", 64'(q_addr.size()), 64'd0);
    check_output("rst_late_writes", 64'(n_wa + n_wb), 64'd0);
    check_output("rst_no_done", 64'(done_cnt), 64'd0);
    apply_stimulus(32'h500, 16'd5, 1'b1);
    wait_done("rst_new_done", 60);
    check_output("rst_new_writes_b", 64'(n_wb), 64'd5);
    check_output("rst_new_wr_err", 64'(wr_err), 64'd0);
    check_output("rst_new_addr_err", 64'(addr_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
